// File: rtl/bp_nonsynth_stall_dump_ctrl_pkg.sv
// Shared types for the stall-reason dump controller: FSM states and counter-bank index map.
// Combinational helpers only; no latency and no flow control live here.
package bp_nonsynth_stall_dump_ctrl_pkg;

  typedef enum logic [0:0] {
    e_count = 1'b0,
    e_drain = 1'b1
  } dump_state_e;

  localparam int commit_idx_lp          = 0;
  localparam int default_num_reasons_lp = 14;
  localparam int unattr_idx_lp          = default_num_reasons_lp + 1;

  // Unattributed bubbles always occupy the slot after the last stall reason.
  function automatic int unattr_idx(input int num_reasons);
    return num_reasons + 1;
  endfunction

endpackage

// File: rtl/bp_nonsynth_sat_counter.sv
// Saturating event counter with a clear-load that seeds the new window with this cycle's event.
// One-cycle update latency; never stalls, it simply sticks at all-ones.
module bp_nonsynth_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               incr,
  output logic [width_p-1:0] count,
  output logic               sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= width_p'(incr);
    end else if (incr && !sat) begin
      count <= count + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_nonsynth_stall_dump_ctrl.sv
// Counts commits/stall reasons and streams a snapshot of all counters on request or period expiry.
// First beat one cycle after the trigger; beats hold while dump_ready_i is low, counting never stops.
module bp_nonsynth_stall_dump_ctrl
  import bp_nonsynth_stall_dump_ctrl_pkg::*;
#(
  parameter  int num_reasons_p   = 14,
  parameter  int counter_width_p = 32,
  parameter  int sample_period_p = 1024,
  localparam int n_lp            = num_reasons_p + 2,
  localparam int idx_width_lp    = $clog2(n_lp)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       freeze_i,
  input  logic                       commit_v_i,
  input  logic [num_reasons_p-1:0]   stall_reason_i,
  input  logic                       dump_req_i,
  output logic                       dump_v_o,
  input  logic                       dump_ready_i,
  output logic [idx_width_lp-1:0]    dump_idx_o,
  output logic [counter_width_p-1:0] dump_data_o,
  output logic                       dump_last_o,
  output logic                       busy_o,
  output logic                       overflow_o
);

  localparam int timer_width_lp = (sample_period_p > 1) ? $clog2(sample_period_p) : 1;
  localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(sample_period_p - 1);
  localparam logic [idx_width_lp-1:0]   last_idx_lp   = idx_width_lp'(unattr_idx(num_reasons_p));

  dump_state_e                state;
  logic [idx_width_lp-1:0]    idx;
  logic                       pending;
  logic                       overflow;
  logic [timer_width_lp-1:0]  timer;
  logic [n_lp-1:0]            incr;
  logic [n_lp-1:0]            sat;
  logic [counter_width_p-1:0] live   [n_lp];
  logic [counter_width_p-1:0] shadow [n_lp];
  logic [counter_width_p-1:0] data_mux;

  logic expiry, trigger, handshake, last_beat, resnap, snap;

  always_comb begin
    incr = '0;
    if (!freeze_i) begin
      if (commit_v_i) begin
        incr[commit_idx_lp] = 1'b1;
      end else if (stall_reason_i == '0) begin
        incr[n_lp-1] = 1'b1;
      end else begin
        incr[num_reasons_p:1] = stall_reason_i;
      end
    end
  end

  assign expiry    = (sample_period_p != 0) && !freeze_i && (timer == timer_last_lp);
  assign trigger   = dump_req_i | expiry;
  assign handshake = (state == e_drain) & dump_ready_i;
  assign last_beat = (idx == last_idx_lp);
  // Last-beat handshake with work queued starts the next dump with no gap.
  assign resnap    = handshake & last_beat & (pending | trigger);
  assign snap      = ((state == e_count) & trigger) | resnap;

  for (genvar i = 0; i < n_lp; i++) begin : g_live
    bp_nonsynth_sat_counter #(
      .width_p(counter_width_p)
    ) u_cnt (
      .clk  (clk_i),
      .reset(reset_i),
      .clear(snap),
      .incr (incr[i]),
      .count(live[i]),
      .sat  (sat[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < n_lp; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < n_lp; i++) shadow[i] <= live[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow <= 1'b0;
      timer    <= '0;
    end else begin
      // A snapshot reloads rather than increments, so it never overflows.
      if (|(incr & sat & ~{n_lp{snap}})) overflow <= 1'b1;
      if (!freeze_i) timer <= (timer == timer_last_lp) ? '0 : timer + timer_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= e_count;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        e_count: begin
          if (trigger) begin
            state <= e_drain;
            idx   <= '0;
          end
        end
        e_drain: begin
          if (handshake && last_beat) begin
            idx     <= '0;
            pending <= 1'b0;
            if (!(pending || trigger)) state <= e_count;
          end else begin
            if (handshake) idx <= idx + idx_width_lp'(1);
            if (trigger) pending <= 1'b1;
          end
        end
        default: state <= e_count;
      endcase
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < n_lp; i++) begin
      if (idx == idx_width_lp'(i)) data_mux = shadow[i];
    end
  end

  assign dump_v_o    = (state == e_drain);
  assign busy_o      = (state == e_drain);
  assign dump_idx_o  = idx;
  assign dump_data_o = data_mux;
  assign dump_last_o = dump_v_o & last_beat;
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_bp_nonsynth_stall_dump_ctrl.sv
// Bench: two controllers (4-bit counters/no period, 32-bit counters/period 8) on shared stimulus,
// each compared every cycle against a window/snapshot model, plus literal expectations for known scenarios.
module tb_bp_nonsynth_stall_dump_ctrl;

  localparam int NR = 14;
  localparam int N  = NR + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, freeze, commit_v, dump_req, dump_ready;
  logic [NR-1:0] reasons;
  logic [1:0]    dv, dl, bz, ov;
  logic [3:0]    di0, di1;
  logic [3:0]    dd0;
  logic [31:0]   dd1;

  bp_nonsynth_stall_dump_ctrl #(
    .num_reasons_p(NR), .counter_width_p(4), .sample_period_p(0)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .commit_v_i(commit_v),
    .stall_reason_i(reasons), .dump_req_i(dump_req), .dump_v_o(dv[0]),
    .dump_ready_i(dump_ready), .dump_idx_o(di0), .dump_data_o(dd0),
    .dump_last_o(dl[0]), .busy_o(bz[0]), .overflow_o(ov[0])
  );

  bp_nonsynth_stall_dump_ctrl #(
    .num_reasons_p(NR), .counter_width_p(32), .sample_period_p(8)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .commit_v_i(commit_v),
    .stall_reason_i(reasons), .dump_req_i(dump_req), .dump_v_o(dv[1]),
    .dump_ready_i(dump_ready), .dump_idx_o(di1), .dump_data_o(dd1),
    .dump_last_o(dl[1]), .busy_o(bz[1]), .overflow_o(ov[1])
  );

  int checks = 0;
  int errors = 0;
  bit model_ok = 0;

  int     per_k [2] = '{0, 8};
  int     wid_k [2] = '{4, 32};
  longint m_cnt [2][N];
  longint m_sh  [2][N];
  bit     m_drain [2];
  int     m_idx [2];
  bit     m_pend [2];
  int     m_timer [2];
  bit     m_ovf [2];
  longint expv [N];

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d expected=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // One clock of the reference: counts go to the open window, a snapshot copies the window out.
  task automatic model_step(input int k);
    longint mx;
    bit     inc [N];
    bit     expiry, trig, hs, lastb, snap;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[k][i] = 0;
        m_sh[k][i]  = 0;
      end
      m_drain[k] = 0; m_idx[k] = 0; m_pend[k] = 0; m_timer[k] = 0; m_ovf[k] = 0;
      return;
    end
    mx = (longint'(1) << wid_k[k]) - 1;
    for (int i = 0; i < N; i++) inc[i] = 0;
    if (!freeze) begin
      if (commit_v) inc[0] = 1;
      else if (reasons == 0) inc[N-1] = 1;
      else for (int r = 0; r < NR; r++) inc[r+1] = reasons[r];
    end
    expiry = (per_k[k] != 0) && !freeze && (m_timer[k] == per_k[k] - 1);
    trig   = dump_req || expiry;
    hs     = m_drain[k] && dump_ready;
    lastb  = (m_idx[k] == N - 1);
    snap   = (!m_drain[k] && trig) || (hs && lastb && (m_pend[k] || trig));
    for (int i = 0; i < N; i++) begin
      if (snap) begin
        m_sh[k][i]  = m_cnt[k][i];
        m_cnt[k][i] = inc[i] ? 1 : 0;
      end else if (inc[i]) begin
        if (m_cnt[k][i] == mx) m_ovf[k] = 1;
        else m_cnt[k][i]++;
      end
    end
    if (!freeze && per_k[k] != 0) m_timer[k] = (m_timer[k] + 1) % per_k[k];
    if (!m_drain[k]) begin
      if (trig) begin m_drain[k] = 1; m_idx[k] = 0; end
    end else if (hs && lastb) begin
      m_idx[k]   = 0;
      m_drain[k] = m_pend[k] || trig;
      m_pend[k]  = 0;
    end else begin
      if (hs) m_idx[k]++;
      if (trig) m_pend[k] = 1;
    end
  endtask

  task automatic compare_inst(input int k);
    longint ai, ad;
    ai = (k == 0) ? longint'(di0) : longint'(di1);
    ad = (k == 0) ? longint'(dd0) : longint'(dd1);
    chk("model_v",    k, dv[k], m_drain[k]);
    chk("model_idx",  k, ai,    m_idx[k]);
    chk("model_data", k, ad,    m_sh[k][m_idx[k]]);
    chk("model_last", k, dl[k], m_drain[k] && m_idx[k] == N - 1);
    chk("model_busy", k, bz[k], m_drain[k]);
    chk("model_ovf",  k, ov[k], m_ovf[k]);
  endtask

  task automatic cyc();
    @(negedge clk);
    if (model_ok) begin
      compare_inst(0);
      compare_inst(1);
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; freeze = 0; commit_v = 0; reasons = '0; dump_req = 0; dump_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic dump_check(input string name, input bit want_ovf);
    dump_ready = 1;
    for (int b = 0; b < N; b++) begin
      chk({name, "_v"},    0, dv[0], 1);
      chk({name, "_idx"},  0, di0,   b);
      chk({name, "_data"}, 0, dd0,   expv[b]);
      chk({name, "_last"}, 0, dl[0], b == N - 1);
      if (want_ovf) chk({name, "_ovf"}, 0, ov[0], 1);
      cyc();
    end
    chk({name, "_end"}, 0, dv[0], 0);
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    reset = 0;
    model_ok = 1;
    chk("rst_v", 0, dv[0], 0);    chk("rst_idx", 0, di0, 0);  chk("rst_data", 0, dd0, 0);
    chk("rst_last", 0, dl[0], 0); chk("rst_busy", 0, bz[0], 0); chk("rst_ovf", 0, ov[0], 0);

    // Period 8 with four frozen cycles: first beat right after the 8th running cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      freeze = (c == 2 || c == 3 || c == 5 || c == 7);
      cyc();
      chk("period_first_v", 1, dv[1], c == 11);
    end
    chk("period_first_idx", 1, di1, 0);
    freeze = 0;

    // Ten commits then a request.
    do_reset();
    commit_v = 1;
    repeat (10) cyc();
    commit_v = 0; dump_req = 1;
    cyc();
    dump_req = 0;
    for (int i = 0; i < N; i++) expv[i] = 0;
    expv[0] = 10;
    dump_check("commits", 0);

    // Reasons 0 and 3 together, then unattributed bubbles.
    do_reset();
    reasons = NR'(9);
    repeat (5) cyc();
    reasons = '0;
    repeat (2) cyc();
    dump_req = 1;
    cyc();
    dump_req = 0;
    for (int i = 0; i < N; i++) expv[i] = 0;
    expv[1] = 5; expv[4] = 5; expv[N-1] = 2;
    dump_check("reasons", 0);

    // Toggling ready with two mid-drain requests: exactly one back-to-back extra dump.
    do_reset();
    commit_v = 1;
    repeat (3) cyc();
    commit_v = 0; dump_req = 1;
    cyc();
    dump_req = 0;
    begin
      int hs = 0;
      int extra = 0;
      bit stalled = 0;
      logic pv;
      logic [3:0] pi, pd;
      for (int t = 0; t < 200; t++) begin
        if (stalled) begin
          chk("stall_v", 0, dv[0], pv); chk("stall_idx", 0, di0, pi); chk("stall_data", 0, dd0, pd);
        end
        if (!dv[0]) break;
        dump_ready = t[0];
        dump_req   = (t == 4 || t == 9);
        pv = dv[0]; pi = di0; pd = dd0;
        stalled = !dump_ready;
        if (dump_ready) hs++;
        cyc();
      end
      dump_req = 0; dump_ready = 1;
      chk("b2b_beats", 0, hs, 2 * N);
      repeat (20) begin
        if (dv[0]) extra++;
        cyc();
      end
      chk("no_third_dump", 0, extra, 0);
    end

    // Saturation of 4-bit counters.
    do_reset();
    commit_v = 1;
    repeat (20) cyc();
    commit_v = 0; dump_req = 1;
    cyc();
    dump_req = 0;
    for (int i = 0; i < N; i++) expv[i] = 0;
    expv[0] = 15;
    dump_check("saturate", 1);
    repeat (3) cyc();
    chk("ovf_sticky", 0, ov[0], 1);
    do_reset();
    chk("ovf_cleared", 0, ov[0], 0);

    // Reset in the middle of a dump.
    commit_v = 1;
    repeat (7) cyc();
    commit_v = 0; dump_req = 1;
    cyc();
    dump_req = 0;
    repeat (5) cyc();
    chk("mid_idx", 0, di0, 5);
    reset = 1;
    cyc();
    reset = 0;
    chk("abort_v", 0, dv[0], 0);
    chk("abort_busy", 0, bz[0], 0);
    dump_req = 1;
    cyc();
    dump_req = 0;
    for (int i = 0; i < N; i++) expv[i] = 0;
    dump_check("after_abort", 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      freeze     = ($urandom_range(0, 7) == 0);
      commit_v   = $urandom_range(0, 1) == 1;
      reasons    = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
      dump_req   = ($urandom_range(0, 24) == 0);
      dump_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
